cla_serial_addsub: RTL and testbench

- Multi-cycle, parametrised adder/subtractor built from carry-lookahead slices.
- Processes CHUNK bits per clock using generate/propagate lookahead within each chunk, and carries between chunks through a register.
- Uses a valid/ready handshake on both input and output.
- Successor to the fixed 32-bit combinational lookahead adder. Used where area matters more than latency, and where producers and consumers may stall.

---
 rtl/cla_serial_addsub.sv | 125 ++++++++++++
 tb/tb_cla_serial_addsub.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_addsub.sv
// Multi-cycle adder/subtractor resolving CHUNK bits per clock with a
// carry-lookahead slice and a registered inter-chunk carry.
module cla_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic [WIDTH-1:0] s_q;
  logic             carry_q, co_q, ov_q;
  logic [CW-1:0]    cnt_q;
  logic             last;

  logic [CHUNK-1:0] g, p, sum;
  logic [CHUNK:0]   c;
  logic             term, sop;

  assign last = (cnt_q == CW'(N - 1));

  // Flattened lookahead: every carry is a direct sum of products of g/p/c0
  always_comb begin
    g    = a_q[CHUNK-1:0] & b_q[CHUNK-1:0];
    p    = a_q[CHUNK-1:0] ^ b_q[CHUNK-1:0];
    c    = '0;
    c[0] = carry_q;
    term = 1'b0;
    sop  = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      term = carry_q;
      for (int j = 0; j <= i; j++) term = term & p[j];
      sop = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        sop = sop | term;
      end
      c[i+1] = sop;
    end
    sum   = p ^ c[CHUNK-1:0];
    acc_d = (WIDTH'(sum) << (WIDTH - CHUNK)) | (acc_q >> CHUNK);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= ci ^ sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          acc_q   <= acc_d;
          carry_q <= c[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            s_q  <= acc_d;
            co_q <= c[CHUNK];
            ov_q <= c[CHUNK-1] ^ c[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

  assign s  = s_q;
  assign co = co_q;
  assign ov = ov_q;

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Directed and model-checked bench driving CHUNK=4, 32 and 1 variants
// of the serial lookahead adder in lockstep.
module tb_cla_serial_addsub;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic        sub, ci;
  logic        out_ready;

  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [31:0] s_w         [3];
  logic        co_w        [3];
  logic        ov_w        [3];

  int lat_exp [3] = '{8, 1, 32};
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cla_serial_addsub #(.WIDTH(32), .CHUNK(4)) u_c4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .sub(sub), .ci(ci),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .s(s_w[0]), .co(co_w[0]), .ov(ov_w[0])
  );

  cla_serial_addsub #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .sub(sub), .ci(ci),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .s(s_w[1]), .co(co_w[1]), .ov(ov_w[1])
  );

  cla_serial_addsub #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .sub(sub), .ci(ci),
    .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .s(s_w[2]), .co(co_w[2]), .ov(ov_w[2])
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic tci);
    a        = ta;
    b        = tb;
    sub      = ts;
    ci       = tci;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] es,
                           input logic ec, input logic eo);
    int lat [3];
    bit busy_ok;
    lat     = '{0, 0, 0};
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (lat[i] == 0) begin
          if (out_valid_w[i]) lat[i] = k;
          else if (in_ready_w[i]) busy_ok = 1'b0;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/%0d lat", tag, i), lat[i], lat_exp[i]);
      chk($sformatf("%s/%0d s", tag, i), s_w[i], es);
      chk($sformatf("%s/%0d co", tag, i), co_w[i], ec);
      chk($sformatf("%s/%0d ov", tag, i), ov_w[i], eo);
    end
    chk({tag, " busy"}, busy_ok, 1);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/%0d rdy", tag, i), in_ready_w[i], 1);
      chk($sformatf("%s/%0d vld", tag, i), out_valid_w[i], 0);
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta,
                       input logic [31:0] tb, input logic ts,
                       input logic tci, input logic [31:0] es,
                       input logic ec, input logic eo);
    start_op(ta, tb, ts, tci);
    wait_done(tag, es, ec, eo);
    release_out(tag);
  endtask

  initial begin
    logic [31:0] ra, rb, bb, es;
    logic        rs, rc, ec, eo;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; ci = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst/%0d rdy", i), in_ready_w[i], 1);
      chk($sformatf("rst/%0d vld", i), out_valid_w[i], 0);
      chk($sformatf("rst/%0d s", i), s_w[i], 0);
      chk($sformatf("rst/%0d co", i), co_w[i], 0);
      chk($sformatf("rst/%0d ov", i), ov_w[i], 0);
    end

    do_op("addco",  32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    do_op("addov",  32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 32'h80000001, 1'b0, 1'b1);
    do_op("addneg", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    do_op("sub",    32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_op("borrow", 32'hA, 32'h3, 1'b1, 1'b1, 32'h6, 1'b1, 1'b0);

    // Result held under backpressure while a new request waits
    start_op(32'h80000000, 32'h1, 1'b1, 1'b0);
    wait_done("subov", 32'h7FFFFFFF, 1'b1, 1'b1);
    a = 32'hA; b = 32'h3; sub = 1'b1; ci = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d s", k), s_w[0], 32'h7FFFFFFF);
      chk($sformatf("bp%0d co", k), co_w[0], 1);
      chk($sformatf("bp%0d ov", k), ov_w[0], 1);
      chk($sformatf("bp%0d vld", k), out_valid_w[0], 1);
      chk($sformatf("bp%0d rdy", k), in_ready_w[0], 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("bprel/%0d rdy", i), in_ready_w[i], 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("bp2", 32'h6, 1'b1, 1'b0);
    release_out("bp2");

    // Reset lands on the third RUN edge of the CHUNK=4 instance
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mrst/%0d rdy", i), in_ready_w[i], 1);
      chk($sformatf("mrst/%0d vld", i), out_valid_w[i], 0);
      chk($sformatf("mrst/%0d s", i), s_w[i], 0);
      chk($sformatf("mrst/%0d co", i), co_w[i], 0);
      chk($sformatf("mrst/%0d ov", i), ov_w[i], 0);
    end
    do_op("postrst", 32'h12345678, 32'h11111111, 1'b0, 1'b0,
          32'h23456789, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      bb = rb ^ {32{rs}};
      {ec, es} = {1'b0, ra} + {1'b0, bb} + {32'h0, rc ^ rs};
      eo = (ra[31] == bb[31]) && (es[31] != ra[31]);
      start_op(ra, rb, rs, rc);
      wait_done($sformatf("rnd%0d", n), es, ec, eo);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      release_out($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
